// File: rtl/gpio_rx_capture_if.sv
`default_nettype none
// ============================================================================
// Module   : gpio_rx_capture_if
// Brief    : Pin, control and event-stream bundle for gpio_rx_capture.
// Revision : 1.0 - initial release
// ============================================================================
interface gpio_rx_capture_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] gpio_pin;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] status_clr;
  logic             ovf_clr;
  logic [WIDTH-1:0] pin_value;
  logic [WIDTH-1:0] status;
  logic             irq;
  logic             evt_valid;
  logic             evt_ready;
  logic [WIDTH-1:0] evt_data;
  logic [WIDTH-1:0] evt_mask;
  logic             overflow;

  // Environment side: drives pins and controls, consumes events.
  modport master (
    output gpio_pin, rise_en, fall_en, status_clr, ovf_clr, evt_ready,
    input  pin_value, status, irq, evt_valid, evt_data, evt_mask, overflow
  );

  // Capture block side.
  modport slave (
    input  gpio_pin, rise_en, fall_en, status_clr, ovf_clr, evt_ready,
    output pin_value, status, irq, evt_valid, evt_data, evt_mask, overflow
  );
endinterface
`default_nettype wire

// File: rtl/gpio_rx_capture.sv
`default_nettype none
// ============================================================================
// Module   : gpio_rx_capture
// Brief    : Synchronise, debounce and edge-detect GPIO pins; sticky status,
//            level irq and a one-deep valid/ready change-event slot.
// Revision : 1.0 - initial release
// ============================================================================
module gpio_rx_capture #(
  parameter int WIDTH           = 32,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  gpio_rx_capture_if.slave bus
);

  localparam int                CNT_W      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] r_pin_value;
  logic [WIDTH-1:0] r_status;
  logic             r_evt_valid;
  logic [WIDTH-1:0] r_evt_data;
  logic [WIDTH-1:0] r_evt_mask;
  logic             r_overflow;

  logic [WIDTH-1:0] w_sync_out;
  logic [WIDTH-1:0] w_upd;
  logic [WIDTH-1:0] w_new_value;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_changed;
  logic             w_any_change;
  logic             w_slot_open;
  logic             w_drop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
    end else begin
      r_sync[0] <= bus.gpio_pin;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
    end
  end

  assign w_sync_out = r_sync[SYNC_STAGES-1];

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    logic [CNT_W-1:0] r_cnt;

    // Counter restarts whenever the input agrees with the stable value or is accepted.
    assign w_upd[i] = (w_sync_out[i] != r_pin_value[i]) && (r_cnt == c_CNT_LAST);

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_cnt <= '0;
      end else if ((w_sync_out[i] == r_pin_value[i]) || w_upd[i]) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + c_CNT_ONE;
      end
    end
  end

  assign w_new_value  = (r_pin_value & ~w_upd) | (w_sync_out & w_upd);
  // An updating pin always flips, so its new level alone tells the edge direction.
  assign w_rise       = w_upd &  w_sync_out & bus.rise_en;
  assign w_fall       = w_upd & ~w_sync_out & bus.fall_en;
  assign w_changed    = w_rise | w_fall;
  assign w_any_change = |w_changed;
  assign w_slot_open  = !r_evt_valid || bus.evt_ready;
  assign w_drop       = w_any_change && !w_slot_open;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pin_value <= '0;
      r_status    <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_pin_value <= w_new_value;
      r_status    <= (r_status & ~bus.status_clr) | w_changed;
      r_overflow  <= (r_overflow & ~bus.ovf_clr) | w_drop;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_evt_valid <= 1'b0;
      r_evt_data  <= '0;
      r_evt_mask  <= '0;
    end else if (w_any_change) begin
      if (w_slot_open) begin
        r_evt_valid <= 1'b1;
        r_evt_data  <= w_new_value;
        r_evt_mask  <= w_changed;
      end
    end else if (r_evt_valid && bus.evt_ready) begin
      r_evt_valid <= 1'b0;
    end
  end

  assign bus.pin_value = r_pin_value;
  assign bus.status    = r_status;
  assign bus.irq       = |r_status;
  assign bus.evt_valid = r_evt_valid;
  assign bus.evt_data  = r_evt_data;
  assign bus.evt_mask  = r_evt_mask;
  assign bus.overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_gpio_rx_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpio_rx_capture
// Brief    : Directed scoreboard bench for gpio_rx_capture (default params).
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpio_rx_capture;

  localparam int WIDTH = 32;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] mask;
  } evt_t;

  evt_t exp_q[$];

  gpio_rx_capture_if #(.WIDTH(WIDTH)) bus ();

  gpio_rx_capture #(
    .WIDTH          (WIDTH),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic consume();
    bus.evt_ready = 1'b1;
    tick();
    bus.evt_ready = 1'b0;
  endtask

  task automatic clear_status(input logic [WIDTH-1:0] m);
    bus.status_clr = m;
    tick();
    bus.status_clr = '0;
  endtask

  // Monitor: every accepted event is popped against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && bus.evt_valid && bus.evt_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", {32'h0, bus.evt_mask}, 64'h0);
      end else begin
        evt_t e;
        e = exp_q.pop_front();
        check("evt_data", {32'h0, bus.evt_data}, {32'h0, e.data});
        check("evt_mask", {32'h0, bus.evt_mask}, {32'h0, e.mask});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    rst_n          = 1'b0;
    bus.gpio_pin   = '0;
    bus.rise_en    = '1;
    bus.fall_en    = '1;
    bus.status_clr = '0;
    bus.ovf_clr    = 1'b0;
    bus.evt_ready  = 1'b0;
    tick(3);
    check("reset_pin_value", {32'h0, bus.pin_value}, 64'h0);
    check("reset_status", {32'h0, bus.status}, 64'h0);
    check("reset_evt_valid", {63'h0, bus.evt_valid}, 64'h0);
    rst_n = 1'b1;
    tick(2);

    // Debounce latency: pin 3 rises, visible after the 6th edge.
    bus.gpio_pin[3] = 1'b1;
    exp_q.push_back('{data: 32'h8, mask: 32'h8});
    tick(5);
    check("lat_not_yet", {32'h0, bus.pin_value}, 64'h0);
    tick();
    check("lat_pin_value", {32'h0, bus.pin_value}, 64'h8);
    check("lat_status", {32'h0, bus.status}, 64'h8);
    check("lat_irq", {63'h0, bus.irq}, 64'h1);
    check("lat_evt_valid", {63'h0, bus.evt_valid}, 64'h1);
    consume();
    check("lat_evt_consumed", {63'h0, bus.evt_valid}, 64'h0);
    clear_status(32'h8);
    check("clr_status", {32'h0, bus.status}, 64'h0);
    check("clr_irq", {63'h0, bus.irq}, 64'h0);

    // Glitch of 3 cycles on pin 0 is rejected.
    bus.gpio_pin[0] = 1'b1;
    tick(3);
    bus.gpio_pin[0] = 1'b0;
    tick(10);
    check("glitch_pin_value", {32'h0, bus.pin_value}, 64'h8);
    check("glitch_status", {32'h0, bus.status}, 64'h0);
    check("glitch_evt_valid", {63'h0, bus.evt_valid}, 64'h0);

    // Pin 5 rise enabled, fall disabled.
    bus.fall_en     = ~32'h20;
    bus.gpio_pin[5] = 1'b1;
    exp_q.push_back('{data: 32'h28, mask: 32'h20});
    tick(10);
    check("en_rise_status", {32'h0, bus.status}, 64'h20);
    bus.gpio_pin[5] = 1'b0;
    tick(10);
    check("en_fall_pin_value", {32'h0, bus.pin_value}, 64'h8);
    check("en_fall_status", {32'h0, bus.status}, 64'h20);
    check("en_fall_no_ovf", {63'h0, bus.overflow}, 64'h0);
    consume();
    check("en_one_event", {63'h0, bus.evt_valid}, 64'h0);
    clear_status(32'h20);

    // Set/clear collision on pin 3.
    bus.gpio_pin[3] = 1'b0;
    exp_q.push_back('{data: 32'h0, mask: 32'h8});
    tick(10);
    check("coll_fall_status", {32'h0, bus.status}, 64'h8);
    consume();
    bus.gpio_pin[3] = 1'b1;
    exp_q.push_back('{data: 32'h8, mask: 32'h8});
    tick(5);
    bus.status_clr = 32'h8;
    tick();
    bus.status_clr = '0;
    check("coll_pin_value", {32'h0, bus.pin_value}, 64'h8);
    check("coll_status_kept", {32'h0, bus.status}, 64'h8);
    consume();
    clear_status(32'h8);
    check("coll_later_clear", {32'h0, bus.status}, 64'h0);
    check("coll_irq_low", {63'h0, bus.irq}, 64'h0);

    // Backpressure: second event dropped, overflow set.
    bus.gpio_pin[1] = 1'b1;
    exp_q.push_back('{data: 32'hA, mask: 32'h2});
    tick(10);
    bus.gpio_pin[2] = 1'b1;
    tick(10);
    check("bp_held_mask", {32'h0, bus.evt_mask}, 64'h2);
    check("bp_held_data", {32'h0, bus.evt_data}, 64'hA);
    check("bp_overflow", {63'h0, bus.overflow}, 64'h1);
    check("bp_status", {32'h0, bus.status}, 64'h6);
    consume();
    check("bp_consumed", {63'h0, bus.evt_valid}, 64'h0);
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    check("bp_ovf_cleared", {63'h0, bus.overflow}, 64'h0);
    clear_status(32'h6);

    // Reset in the middle of a pin-4 debounce.
    bus.gpio_pin[4] = 1'b1;
    tick(2);
    rst_n = 1'b0;
    tick();
    check("rst_pin_value", {32'h0, bus.pin_value}, 64'h0);
    check("rst_status", {32'h0, bus.status}, 64'h0);
    check("rst_irq", {63'h0, bus.irq}, 64'h0);
    check("rst_evt_valid", {63'h0, bus.evt_valid}, 64'h0);
    check("rst_evt_data", {32'h0, bus.evt_data}, 64'h0);
    check("rst_evt_mask", {32'h0, bus.evt_mask}, 64'h0);
    check("rst_overflow", {63'h0, bus.overflow}, 64'h0);
    rst_n = 1'b1;
    // Pins 1..4 are all high, so they rise together after release.
    exp_q.push_back('{data: 32'h1E, mask: 32'h1E});
    tick(5);
    check("rel_not_yet", {32'h0, bus.pin_value}, 64'h0);
    tick();
    check("rel_pin_value", {32'h0, bus.pin_value}, 64'h1E);
    check("rel_status", {32'h0, bus.status}, 64'h1E);
    consume();

    tick(2);
    check("scoreboard_empty", 64'(exp_q.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
